// File: rtl/lcd_seq_loader.sv
// lcd_seq_loader
// Power-up and message sequencer feeding the LCD command/data FIFO.
// Emits the four HD44780 init commands (0x38, 0x0C, 0x01, 0x06), then
// MSG_LEN characters read from an external message source, then parks in
// DONE until the next start.
//
// Optional build macro: LCD_LINE2_EN
//   When defined and MSG_LEN > LINE_LEN, a set-DDRAM-address command (0xC0)
//   is inserted after character LINE_LEN-1 so the text wraps onto line 2.
//   When undefined, characters are emitted contiguously and LINE_LEN is
//   ignored.
//
// FIFO handshake: fifo_full is an almost-full flag sampled at each rising
// edge. When it is low at an edge, one entry is registered onto
// data_out/rs_out with wr_en high for exactly that cycle and the sequence
// advances. When it is high, wr_en drops and the pending entry, index and
// state all hold. The FIFO absorbs the single write issued in the cycle
// where full rises.
//
// dbg_state exposes the FSM state for checkers.

module lcd_seq_loader #(
    parameter int DATA_W   = 8,
    parameter int MSG_LEN  = 13,
    parameter int LINE_LEN = 16,
    parameter int IDX_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fifo_full,
    input  logic [DATA_W-1:0] msg_data,
    output logic [IDX_W-1:0]  msg_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              rs_out,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_MSG   = 3'd2,
        S_LINE2 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef LCD_LINE2_EN
    localparam bit LINE2_BUILD = 1'b1;
`else
    localparam bit LINE2_BUILD = 1'b0;
`endif

    // The line break only exists when the message actually spills past line 1.
    localparam bit DO_SPLIT = LINE2_BUILD && (MSG_LEN > LINE_LEN);

    localparam logic [IDX_W-1:0] IDX_INIT_LAST = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_MSG_END   = IDX_W'(MSG_LEN);
    localparam logic [IDX_W-1:0] IDX_MSG_LAST  = IDX_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LINE_LAST = IDX_W'(LINE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LINE2     = IDX_W'(LINE_LEN);

    localparam logic [DATA_W-1:0] CMD_FUNC_SET = DATA_W'(8'h38);
    localparam logic [DATA_W-1:0] CMD_DISP_ON  = DATA_W'(8'h0C);
    localparam logic [DATA_W-1:0] CMD_CLEAR    = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] CMD_ENTRY    = DATA_W'(8'h06);
    localparam logic [DATA_W-1:0] CMD_LINE2    = DATA_W'(8'hC0);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_rs;
    logic                r_wr;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_rs_nxt;
    logic                w_wr_nxt;
    logic [DATA_W-1:0]   w_init_cmd;

    // Select the init command addressed by the index while in INIT.
    always_comb begin
        w_init_cmd = CMD_FUNC_SET;
        case (r_idx[1:0])
            2'd0:    w_init_cmd = CMD_FUNC_SET;
            2'd1:    w_init_cmd = CMD_DISP_ON;
            2'd2:    w_init_cmd = CMD_CLEAR;
            default: w_init_cmd = CMD_ENTRY;
        endcase
    end

    // Next-state and next-output logic; every path holds unless it emits.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_rs_nxt    = r_rs;
        w_wr_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_INIT;
                    w_idx_nxt   = '0;
                end
            end
            S_INIT: begin
                if (!fifo_full) begin
                    w_data_nxt = w_init_cmd;
                    w_rs_nxt   = 1'b0;
                    w_wr_nxt   = 1'b1;
                    if (r_idx == IDX_INIT_LAST) begin
                        w_state_nxt = S_MSG;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_MSG: begin
                // Index past the last character: the last write has gone
                // out on the previous edge, so close the sequence.
                if (r_idx == IDX_MSG_END) begin
                    w_state_nxt = S_DONE;
                end else if (!fifo_full) begin
                    w_data_nxt = msg_data;
                    w_rs_nxt   = 1'b1;
                    w_wr_nxt   = 1'b1;
                    if (DO_SPLIT && (r_idx == IDX_LINE_LAST)) begin
                        w_state_nxt = S_LINE2;
                        w_idx_nxt   = IDX_LINE2;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
`ifdef LCD_LINE2_EN
            S_LINE2: begin
                // Index already points at the first line-2 character.
                if (!fifo_full) begin
                    w_data_nxt  = CMD_LINE2;
                    w_rs_nxt    = 1'b0;
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = S_MSG;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // State, index and the registered FIFO write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_rs    <= w_rs_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    // Message address follows the index while characters are being fetched;
    // clamped so it never leaves 0..MSG_LEN-1.
    always_comb begin
        msg_addr = '0;
        if ((r_state == S_MSG) || (r_state == S_LINE2)) begin
            if (r_idx >= IDX_MSG_END) begin
                msg_addr = IDX_MSG_LAST;
            end else begin
                msg_addr = r_idx;
            end
        end
    end

    assign data_out  = r_data;
    assign rs_out    = r_rs;
    assign wr_en     = r_wr;
    assign busy      = (r_state == S_INIT) || (r_state == S_MSG) || (r_state == S_LINE2);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lcd_seq_loader.sv
// tb_lcd_seq_loader
// Two sequencer instances: A with a 4-character message "ABCD", B with an
// 18-character message on a 16-character line (exercises LCD_LINE2_EN when
// the macro is defined). Expected FIFO entries {rs, data} are queued when a
// sequence is started; a monitor pops one per wr_en cycle and compares.

`timescale 1ns/1ps

module tb_lcd_seq_loader;

    logic       clk;
    logic       rst;

    logic       start_a, full_a;
    logic [7:0] msg_data_a;
    logic [5:0] msg_addr_a;
    logic [7:0] data_out_a;
    logic       rs_a, wr_en_a, busy_a, done_a;
    logic [2:0] dbg_a;

    logic       start_b, full_b;
    logic [7:0] msg_data_b;
    logic [5:0] msg_addr_b;
    logic [7:0] data_out_b;
    logic       rs_b, wr_en_b, busy_b, done_b;
    logic [2:0] dbg_b;

`ifdef LCD_LINE2_EN
    localparam int B_WRITES = 23;
`else
    localparam int B_WRITES = 22;
`endif

    logic [8:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];
    logic [8:0] exp_a, exp_b;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int c0;
    int cyc;

    lcd_seq_loader #(.DATA_W(8), .MSG_LEN(4), .LINE_LEN(16), .IDX_W(6)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .fifo_full(full_a),
        .msg_data(msg_data_a), .msg_addr(msg_addr_a), .data_out(data_out_a),
        .rs_out(rs_a), .wr_en(wr_en_a), .busy(busy_a), .done(done_a),
        .dbg_state(dbg_a)
    );

    lcd_seq_loader #(.DATA_W(8), .MSG_LEN(18), .LINE_LEN(16), .IDX_W(6)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .fifo_full(full_b),
        .msg_data(msg_data_b), .msg_addr(msg_addr_b), .data_out(data_out_b),
        .rs_out(rs_b), .wr_en(wr_en_b), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_b)
    );

    // Message sources: A reads "ABCD", B reads "abcd...".
    assign msg_data_a = 8'h41 + 8'(msg_addr_a);
    assign msg_data_b = 8'h61 + 8'(msg_addr_b);

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && wr_en_a === 1'b1) begin
            wr_cnt_a++;
            if (exp_a_q.size() == 0) begin
                n_checks++;
                $display("FAIL a_unexpected_write: got 0x%0h expected none", {rs_a, data_out_a});
            end else begin
                exp_a = exp_a_q.pop_front();
                check("a_write", {23'd0, rs_a, data_out_a}, {23'd0, exp_a});
            end
        end
        if (rst === 1'b1 && wr_en_b === 1'b1) begin
            wr_cnt_b++;
            if (exp_b_q.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected_write: got 0x%0h expected none", {rs_b, data_out_b});
            end else begin
                exp_b = exp_b_q.pop_front();
                check("b_write", {23'd0, rs_b, data_out_b}, {23'd0, exp_b});
            end
        end
    end

    // Driver tasks
    task automatic push_init(input bit to_b);
        logic [8:0] cmds [4];
        cmds[0] = 9'h038; cmds[1] = 9'h00C; cmds[2] = 9'h001; cmds[3] = 9'h006;
        for (int i = 0; i < 4; i++) begin
            if (to_b) exp_b_q.push_back(cmds[i]);
            else      exp_a_q.push_back(cmds[i]);
        end
    endtask

    task automatic push_a_seq();
        push_init(1'b0);
        for (int i = 0; i < 4; i++) exp_a_q.push_back({1'b1, 8'h41 + 8'(i)});
    endtask

    task automatic push_b_seq();
        push_init(1'b1);
        for (int i = 0; i < 18; i++) begin
`ifdef LCD_LINE2_EN
            if (i == 16) exp_b_q.push_back(9'h0C0);
`endif
            exp_b_q.push_back({1'b1, 8'h61 + 8'(i)});
        end
    endtask

    // Returns at the falling edge right after the edge that samples start.
    task automatic pulse_start_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (done_a !== 1'b1 && n < 200);
    endtask

    task automatic wait_done_b(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (done_b !== 1'b1 && n < 200);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; full_a = 1'b0; start_b = 1'b0; full_b = 1'b0;

        // Asynchronous reset mid-clock, then idle with start low.
        #2 rst = 1'b0;
        #1;
        check("rst_wr_en",    {31'd0, wr_en_a}, 32'd0);
        check("rst_rs_out",   {31'd0, rs_a},    32'd0);
        check("rst_data_out", {24'd0, data_out_a}, 32'd0);
        check("rst_busy",     {31'd0, busy_a},  32'd0);
        check("rst_done",     {31'd0, done_a},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        c0 = wr_cnt_a;
        repeat (20) @(negedge clk);
        #1;
        check("idle_no_writes", wr_cnt_a - c0, 32'd0);
        check("idle_busy", {31'd0, busy_a}, 32'd0);

        // Plain run: 8 back-to-back writes, done one edge later.
        c0 = wr_cnt_a;
        push_a_seq();
        pulse_start_a();
        wait_done_a(cyc);
        #1;
        check("run_done_cycle", cyc, 32'd9);
        check("run_writes", wr_cnt_a - c0, 32'd8);
        check("run_done", {31'd0, done_a}, 32'd1);
        check("run_busy", {31'd0, busy_a}, 32'd0);
        check("run_queue_empty", exp_a_q.size(), 32'd0);

        // Back-pressure for 3 edges while 0x01 is pending.
        c0 = wr_cnt_a;
        push_a_seq();
        pulse_start_a();
        @(negedge clk);
        @(negedge clk);
        full_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_wr_en", {31'd0, wr_en_a}, 32'd0);
            check("bp_stall_busy", {31'd0, busy_a}, 32'd1);
        end
        full_a = 1'b0;
        wait_done_a(cyc);
        #1;
        check("bp_done_cycle", cyc, 32'd7);
        check("bp_writes", wr_cnt_a - c0, 32'd8);
        check("bp_queue_empty", exp_a_q.size(), 32'd0);

        // start while busy is ignored; start in DONE restarts.
        c0 = wr_cnt_a;
        push_a_seq();
        pulse_start_a();
        @(negedge clk);
        pulse_start_a();
        @(negedge clk);
        pulse_start_a();
        wait_done_a(cyc);
        #1;
        check("busy_start_writes", wr_cnt_a - c0, 32'd8);
        check("busy_start_done", {31'd0, done_a}, 32'd1);
        c0 = wr_cnt_a;
        push_a_seq();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_done_low", {31'd0, done_a}, 32'd0);
        check("restart_busy", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        #1;
        check("restart_first_wr", {31'd0, wr_en_a}, 32'd1);
        check("restart_first_data", {23'd0, rs_a, data_out_a}, 32'h038);
        wait_done_a(cyc);
        #1;
        check("restart_writes", wr_cnt_a - c0, 32'd8);

        // Reset after the 5th write aborts with no residual write.
        c0 = wr_cnt_a;
        push_a_seq();
        pulse_start_a();
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_wr_en", {31'd0, wr_en_a}, 32'd0);
        check("abort_busy",  {31'd0, busy_a},  32'd0);
        check("abort_data",  {23'd0, rs_a, data_out_a}, 32'd0);
        check("abort_writes_before", wr_cnt_a - c0, 32'd5);
        exp_a_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        c0 = wr_cnt_a;
        repeat (5) @(negedge clk);
        #1;
        check("abort_no_residual", wr_cnt_a - c0, 32'd0);
        push_a_seq();
        pulse_start_a();
        wait_done_a(cyc);
        #1;
        check("abort_rerun_cycle", cyc, 32'd9);
        check("abort_rerun_writes", wr_cnt_a - c0, 32'd8);

        // Long message across the line boundary.
        c0 = wr_cnt_b;
        push_b_seq();
        pulse_start_b();
        wait_done_b(cyc);
        #1;
        check("b_done_cycle", cyc, B_WRITES + 1);
        check("b_writes", wr_cnt_b - c0, B_WRITES);
        check("b_done", {31'd0, done_b}, 32'd1);
        check("b_queue_empty", exp_b_q.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_seq_loader.md
Name: lcd_seq_loader

Overview:
- Parametrised LCD power-up and message sequencer that writes into the LCD command/data FIFO.
- Issues the fixed HD44780 init commands, then MSG_LEN message characters fetched from an external message source, each tagged command or data.
- Runs from an internal index with FIFO back-pressure and start/done handshakes; no external count is needed.
- Sits between the message ROM/register file and the FIFO that feeds the LCD driver.

Parameters:
- DATA_W, 8, width of FIFO data word and message character.
- MSG_LEN, 13, number of message characters; legal range 1..32.
- LINE_LEN, 16, characters per LCD line; used only with LCD_LINE2_EN.
- IDX_W, 6, width of internal index and msg_addr; must hold 4+MSG_LEN+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence; honoured in IDLE or DONE only.
- fifo_full  in  1  FIFO cannot accept a write issued next cycle (almost-full semantics; FIFO must absorb the write issued in the cycle full rises).
- msg_data  in  DATA_W  character at msg_addr; combinational, valid the same cycle.
- msg_addr  out  IDX_W  message character index, 0..MSG_LEN-1; combinational from internal state.
- data_out  out  DATA_W  FIFO write data, registered.
- rs_out  out  1  0 = command, 1 = character data; registered, aligned with data_out.
- wr_en  out  1  FIFO write strobe, registered, one cycle per entry.
- busy  out  1  high in INIT, MSG and LINE2.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; index 0.
  - wr_en, rs_out, busy and done are 0; data_out is 0.
- States are IDLE, INIT, MSG, LINE2 and DONE.
- IDLE:
  - start=1 at an edge -> INIT, index<=0.
  - First wr_en appears at the second edge after start is sampled, provided fifo_full=0.
- Emit rule (INIT/MSG/LINE2), at each edge:
  - If fifo_full=0: register data_out and rs_out, set wr_en<=1, and advance.
  - If fifo_full=1: wr_en<=0; index, state, data_out and rs_out hold.
  - wr_en is never high for two edges on the same entry.
- INIT:
  - Emits 0x38, 0x0C, 0x01, 0x06 with rs_out=0.
  - After emitting 0x06 -> MSG, msg index 0.
- MSG:
  - Emits msg_data at msg_addr with rs_out=1.
  - After character MSG_LEN-1 -> DONE.
- DONE:
  - At the edge that enters DONE, wr_en<=0 and done<=1.
  - done holds until start.
  - start=1 in DONE -> INIT: done<=0, index<=0, and the full sequence re-runs.
- start while busy=1 is ignored.
- Total writes per sequence = 4 + MSG_LEN (+1 with LCD_LINE2_EN when MSG_LEN>LINE_LEN).
- With no back-pressure, writes are back-to-back and done rises one edge after the last wr_en edge.
- Reset mid-sequence aborts immediately to IDLE; no partial-entry write follows reset release.
- fifo_full is sampled only at edges; glitches between edges are irrelevant.

Optional Feature:
- Macro: LCD_LINE2_EN.
- Defined:
  - After the character with msg_addr = LINE_LEN-1 is emitted, and if MSG_LEN>LINE_LEN, the state goes to LINE2.
  - LINE2 emits command 0xC0 (rs_out=0) under the same emit rule, then returns to MSG at msg_addr=LINE_LEN.
  - msg_addr holds at LINE_LEN during LINE2.
- Not defined:
  - No LINE2 state; characters are emitted contiguously.
  - LINE_LEN is unused.

Test Plan:
- Reset with rst=0 mid-clock -> all outputs 0 immediately; state IDLE; start held 0 -> no wr_en for 20 cycles.
- MSG_LEN=4, msg source "ABCD", fifo_full=0, start pulse:
  - FIFO sees 0x38/0, 0x0C/0, 0x01/0, 0x06/0, 0x41/1, 0x42/1, 0x43/1, 0x44/1 (data/rs) on 8 consecutive wr_en cycles.
  - done=1 the cycle after; busy=0.
- Same MSG_LEN=4 run with fifo_full forced 1 for 3 cycles while 0x01 is pending:
  - wr_en=0 for 3 cycles; no duplicate or skipped entry.
  - Exactly 8 writes, sequence identical to the no-back-pressure run.
- start pulses during busy plus a start in DONE:
  - Mid-sequence pulses are ignored (still 8 writes).
  - The DONE start restarts: done falls, and 0x38 is written again 2 cycles later.
- rst asserted after the 5th write, then released and start pulsed -> the new sequence begins from 0x38; no residual write.
- LCD_LINE2_EN, LINE_LEN=16, MSG_LEN=18:
  - 0xC0/rs=0 is written between character 15 and character 16; 23 writes total.
  - Without the macro: 22 writes, with no 0xC0.
